// File: rtl/core_pkg.sv
// Shared types and elaboration helpers for the up/down counter family.
package core_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_e;

    // Legal counting range: 2 <= modulus <= 2**width.
    function automatic bit modulus_ok(input int width, input longint modulus);
        return (modulus >= 2) && (modulus <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             carry;
    logic             sat;
    logic             load_err;

    modport master (
        output en, load, load_val, dir,
        input  count, tc, carry, sat, load_err
    );

    modport slave (
        input  en, load, load_val, dir,
        output count, tc, carry, sat, load_err
    );
endinterface

// File: rtl/updown_counter_next.sv
// Combinational step logic: next count for one enabled edge and range-end detect.
module counter_next
    import core_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  count_dir_e       dir,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             end_reached
);
    // One extra bit so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] nxt_ext;

    always_comb begin
        cnt_ext     = {1'b0, count};
        nxt_ext     = cnt_ext;
        end_reached = 1'b0;
        if (dir == DIR_UP) begin
            end_reached = (cnt_ext == MAX_EXT);
            if (!end_reached)
                nxt_ext = cnt_ext + 1'b1;
            else if (!mode)
                nxt_ext = '0;
        end else begin
            end_reached = (cnt_ext == '0);
            if (!end_reached)
                nxt_ext = cnt_ext - 1'b1;
            else if (!mode)
                nxt_ext = MAX_EXT;
        end
        next_count = nxt_ext[WIDTH-1:0];
    end
endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate, carry pulse and load range error.
module updown_counter
    import core_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    updown_counter_if.slave  bus
);
    if (!modulus_ok(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
        $error("updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             sat_q, sat_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] step_count;
    logic             step_end;
    count_dir_e       dir;

    assign dir = count_dir_e'(bus.dir);

    counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count       (count_q),
        .dir         (dir),
        .mode        (SATURATE != 0),
        .next_count  (step_count),
        .end_reached (step_end)
    );

    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        sat_d      = sat_q;
        if (bus.load) begin
            sat_d = 1'b0;
            if ({1'b0, bus.load_val} >= MOD_EXT) begin
                count_d    = MAX_EXT[WIDTH-1:0];
                load_err_d = 1'b1;
            end else begin
                count_d = bus.load_val;
            end
        end else if (bus.en) begin
            count_d = step_count;
            if (step_end) begin
                if (SATURATE != 0)
                    sat_d = 1'b1;
                else
                    carry_d = 1'b1;
            end else begin
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    // Terminal count follows dir immediately, independent of en.
    assign bus.tc       = (dir == DIR_UP) ? ({1'b0, count_q} == MAX_EXT) : (count_q == '0);
    assign bus.count    = count_q;
    assign bus.carry    = carry_q;
    assign bus.sat      = sat_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_updown_counter.sv
// Directed vector bench for updown_counter across wrap/saturate and full-range configs.
module tb_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ld, en, dir;
    logic [3:0] lv;

    updown_counter_if #(.WIDTH(4)) if0 ();
    updown_counter_if #(.WIDTH(4)) if1 ();
    updown_counter_if #(.WIDTH(4)) if2 ();

    assign if0.en = en; assign if0.load = ld; assign if0.load_val = lv; assign if0.dir = dir;
    assign if1.en = en; assign if1.load = ld; assign if1.load_val = lv; assign if1.dir = dir;
    assign if2.en = en; assign if2.load = ld; assign if2.load_val = lv; assign if2.dir = dir;

    // sel 0: MOD10 wrap, sel 1: MOD10 saturate, sel 2: MOD16 wrap
    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
    updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

    typedef struct {
        int         sel;
        logic       rst, ld, en, dir;
        logic [3:0] lv;
        logic [3:0] cnt;
        logic       tc, cy, st, le;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input int s, input logic r, input logic l, input logic e, input logic d,
                       input logic [3:0] v, input logic [3:0] c, input logic t, input logic cy,
                       input logic st, input logic le);
        vec_t x;
        x.sel = s; x.rst = r; x.ld = l; x.en = e; x.dir = d; x.lv = v;
        x.cnt = c; x.tc = t; x.cy = cy; x.st = st; x.le = le;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic get(input int s, output logic [3:0] c, output logic t, output logic cy,
                       output logic st, output logic le);
        case (s)
            0:       begin c = if0.count; t = if0.tc; cy = if0.carry; st = if0.sat; le = if0.load_err; end
            1:       begin c = if1.count; t = if1.tc; cy = if1.carry; st = if1.sat; le = if1.load_err; end
            default: begin c = if2.count; t = if2.tc; cy = if2.carry; st = if2.sat; le = if2.load_err; end
        endcase
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic d, input logic [3:0] v);
        @(negedge clk);
        rst = r; ld = l; en = e; dir = d; lv = v;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] a_c;
    logic       a_t, a_cy, a_st, a_le;
    int         model;

    initial begin
        rst = 1'b1; ld = 1'b0; en = 1'b0; dir = 1'b0; lv = '0;

        // Test 1: MOD10 wrap, up 12 clocks
        add(0, 1,0,0,0, 0, 0, 0,0,0,0);
        for (int i = 1; i <= 12; i++) begin
            int c;
            c = i % 10;
            add(0, 0,0,1,0, 0, 4'(c), (c == 9), (c == 0), 0, 0);
        end
        // Test 2: load 3, down 5 clocks
        add(0, 0,1,0,0, 3, 3, 0,0,0,0);
        add(0, 0,0,1,1, 0, 2, 0,0,0,0);
        add(0, 0,0,1,1, 0, 1, 0,0,0,0);
        add(0, 0,0,1,1, 0, 0, 1,0,0,0);
        add(0, 0,0,1,1, 0, 9, 0,1,0,0);
        add(0, 0,0,1,1, 0, 8, 0,0,0,0);
        // Test 4: illegal load, boundary loads, load beats enable
        add(0, 0,1,0,0, 12, 9, 1,0,0,1);
        add(0, 0,0,0,0, 0,  9, 1,0,0,0);
        add(0, 0,1,1,0, 4,  4, 0,0,0,0);
        add(0, 0,0,1,0, 0,  5, 0,0,0,0);
        add(0, 0,1,0,0, 10, 9, 1,0,0,1);
        add(0, 0,1,0,0, 9,  9, 1,0,0,0);
        // carry pulse discarded by reset
        add(0, 0,0,1,0, 0,  0, 0,1,0,0);
        add(0, 1,0,0,0, 0,  0, 0,0,0,0);
        // Test 6: reset mid-count wins over load and en
        add(0, 0,1,0,0, 5,  5, 0,0,0,0);
        add(0, 0,0,1,0, 0,  6, 0,0,0,0);
        add(0, 1,1,1,0, 3,  0, 0,0,0,0);
        add(0, 0,0,1,0, 0,  1, 0,0,0,0);
        // Test 3: MOD10 saturate
        add(1, 1,0,0,0, 0, 0, 0,0,0,0);
        add(1, 0,1,0,0, 8, 8, 0,0,0,0);
        add(1, 0,0,1,0, 0, 9, 1,0,0,0);
        add(1, 0,0,1,0, 0, 9, 1,0,1,0);
        add(1, 0,0,1,0, 0, 9, 1,0,1,0);
        add(1, 0,0,1,1, 0, 8, 0,0,0,0);
        add(1, 0,1,0,1, 0, 0, 1,0,0,0);
        add(1, 0,0,1,1, 0, 0, 1,0,1,0);
        add(1, 0,0,0,1, 0, 0, 1,0,1,0);
        add(1, 0,1,0,1, 5, 5, 0,0,0,0);
        add(1, 0,1,0,0, 15,9, 1,0,0,1);
        // Test 5: MOD16 full range
        add(2, 1,0,0,0, 0,  0,  0,0,0,0);
        add(2, 0,1,0,0, 15, 15, 1,0,0,0);
        add(2, 0,0,1,0, 0,  0,  0,1,0,0);
        add(2, 0,0,1,1, 0,  15, 0,1,0,0);
        add(2, 0,0,1,1, 0,  14, 0,0,0,0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].ld, vq[i].en, vq[i].dir, vq[i].lv);
            get(vq[i].sel, a_c, a_t, a_cy, a_st, a_le);
            chk("count",    i, a_c,          vq[i].cnt);
            chk("tc",       i, {3'b0, a_t},  {3'b0, vq[i].tc});
            chk("carry",    i, {3'b0, a_cy}, {3'b0, vq[i].cy});
            chk("sat",      i, {3'b0, a_st}, {3'b0, vq[i].st});
            chk("load_err", i, {3'b0, a_le}, {3'b0, vq[i].le});
        end

        // tc follows dir without a clock edge (MOD10 at count 0)
        step(1, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; dir = 1'b0; #1;
        chk("tc_dir_up",   100, {3'b0, if0.tc}, 4'd0);
        dir = 1'b1; #1;
        chk("tc_dir_down", 101, {3'b0, if0.tc}, 4'd1);

        // down-count run on MOD10 wrap against a modulo model
        model = 0;
        for (int i = 0; i < 23; i++) begin
            step(0, 0, 1, 1, 0);
            model = (model + 9) % 10;
            chk("down_run_count", 200 + i, if0.count, 4'(model));
            chk("down_run_carry", 200 + i, {3'b0, if0.carry}, {3'b0, (model == 9)});
        end

        // en low with dir flips: count must hold
        step(0, 0, 0, 0, 0);
        chk("hold_count", 300, if0.count, 4'(model));
        step(0, 0, 0, 1, 0);
        chk("hold_count2", 301, if0.count, 4'(model));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
